// File: rtl/demux441_seq_pkg.sv
// rtl/demux441_seq_pkg.sv - shared types and constants for the nibble demultiplexer
package demux_pkg;
    localparam int NUM_SLOTS = 4;
    localparam int DEF_WIDTH = 4;

    typedef logic [1:0] slot_t;
endpackage

// File: rtl/demux441_seq_if.sv
// rtl/demux441_seq_if.sv - multiplexed word input and committed frame output bundle
// Signals: din/din_valid/sync (word stream in), s (slot select, DEMUX_EXT_SEL_EN only),
//          O0..O3 (committed frame), frame_valid/frame_abort (one-cycle pulses).
// master = stream source / frame consumer side, slave = demultiplexer side.
interface demux441_seq_if
    import demux_pkg::*;
#(
    parameter int W = DEF_WIDTH
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         sync;
`ifdef DEMUX_EXT_SEL_EN
    slot_t        s;
`endif
    logic [W-1:0] O0;
    logic [W-1:0] O1;
    logic [W-1:0] O2;
    logic [W-1:0] O3;
    logic         frame_valid;
    logic         frame_abort;

    modport master (
`ifdef DEMUX_EXT_SEL_EN
        output s,
`endif
        output din, din_valid, sync,
        input  O0, O1, O2, O3, frame_valid, frame_abort
    );

    modport slave (
`ifdef DEMUX_EXT_SEL_EN
        input  s,
`endif
        input  din, din_valid, sync,
        output O0, O1, O2, O3, frame_valid, frame_abort
    );
endinterface

// File: rtl/demux_slot_ctr.sv
// rtl/demux_slot_ctr.sv - 2-bit slot counter with advance, commit wrap, sync clear and abort detect
// Ports: clk, rst_n (async active-low), din_valid, sync (inputs);
//        slot (current slot), commit (4th word accepted this cycle),
//        abort (sync arrives while a partial frame is staged) -- commit/abort are combinational.
module demux_slot_ctr
    import demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  din_valid,
    input  logic  sync,
    output slot_t slot,
    output logic  commit,
    output logic  abort
);
    assign commit = din_valid && !sync && (slot == slot_t'(NUM_SLOTS - 1));
    assign abort  = sync && (slot != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (sync) begin
            // A word accompanying sync lands in slot 0, so the next one goes to slot 1.
            slot <= din_valid ? slot_t'(1) : slot_t'(0);
        end else if (din_valid) begin
            // Natural 2-bit overflow gives the 3->0 wrap exactly on commit.
            slot <= slot + slot_t'(1);
        end
    end
endmodule

// File: rtl/demux441_seq.sv
// rtl/demux441_seq.sv - sequential 1-to-4 word demultiplexer with framed commit
// Ports: clk, rst_n (async active-low), bus (demux441_seq_if.slave).
// Optional macro DEMUX_EXT_SEL_EN: slot chosen by bus.s instead of the internal counter;
// sync then clears staging and frame_abort is held at 0.
module demux441_seq
    import demux_pkg::*;
#(
    parameter int W = DEF_WIDTH
)(
    input  logic          clk,
    input  logic          rst_n,
    demux441_seq_if.slave bus
);
    logic [W-1:0] st  [NUM_SLOTS];
    logic [W-1:0] o_q [NUM_SLOTS];
    logic         fv_q;
    logic         fa_q;
    logic         commit;
    logic         abort;
    slot_t        wsel;

`ifdef DEMUX_EXT_SEL_EN
    assign wsel   = bus.s;
    assign commit = bus.din_valid && !bus.sync && (bus.s == slot_t'(NUM_SLOTS - 1));
    assign abort  = 1'b0;
`else
    demux_slot_ctr u_slot_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_valid (bus.din_valid),
        .sync      (bus.sync),
        .slot      (wsel),
        .commit    (commit),
        .abort     (abort)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                st[i]  <= '0;
                o_q[i] <= '0;
            end
            fv_q <= 1'b0;
            fa_q <= 1'b0;
        end else begin
            fv_q <= commit;
            fa_q <= abort;
`ifdef DEMUX_EXT_SEL_EN
            if (bus.sync) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    st[i] <= '0;
                end
            end else if (bus.din_valid) begin
                st[wsel] <= bus.din;
            end
`else
            // Stale st1..st3 after a sync are left alone; the next frame rewrites them before commit.
            if (bus.din_valid) begin
                if (bus.sync) begin
                    st[0] <= bus.din;
                end else begin
                    st[wsel] <= bus.din;
                end
            end
`endif
            // The last word bypasses staging so the frame is visible right after its own edge.
            if (commit) begin
                o_q[0] <= st[0];
                o_q[1] <= st[1];
                o_q[2] <= st[2];
                o_q[3] <= bus.din;
            end
        end
    end

    assign bus.O0          = o_q[0];
    assign bus.O1          = o_q[1];
    assign bus.O2          = o_q[2];
    assign bus.O3          = o_q[3];
    assign bus.frame_valid = fv_q;
    assign bus.frame_abort = fa_q;
endmodule

// File: tb/tb_demux441_seq.sv
// tb/tb_demux441_seq.sv - directed self-checking bench for demux441_seq
module tb_demux441_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [15:0] frame;

    demux441_seq_if #(.W(4)) bus ();

    demux441_seq #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign frame = {bus.O0, bus.O1, bus.O2, bus.O3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, let the edge happen, and leave outputs settled 1 time unit later.
    task automatic step(input logic v, input logic sy, input logic [3:0] d);
        bus.din       = d;
        bus.din_valid = v;
        bus.sync      = sy;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (frame !== 16'h0000) begin
            $display("FAIL reset_frame: got %h want %h", frame, 16'h0000); n_fail++;
        end
        n_checks++;
        if (bus.frame_valid !== 1'b0 || bus.frame_abort !== 1'b0) begin
            $display("FAIL reset_pulses: got fv=%b fa=%b want 0 0", bus.frame_valid, bus.frame_abort); n_fail++;
        end
        n_checks++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifndef DEMUX_EXT_SEL_EN
    task automatic test_basic_frame;
        logic [3:0] words [4];
        words = '{4'h1, 4'h2, 4'h3, 4'h4};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, words[i]);
            if (bus.frame_valid !== 1'b0 || frame !== 16'h0000) begin
                $display("FAIL basic_pre_%0d: got fv=%b frame=%h want 0 0000", i, bus.frame_valid, frame); n_fail++;
            end
            n_checks++;
        end
        step(1'b1, 1'b0, words[3]);
        if (bus.frame_valid !== 1'b1 || frame !== 16'h1234) begin
            $display("FAIL basic_commit: got fv=%b frame=%h want 1 1234", bus.frame_valid, frame); n_fail++;
        end
        n_checks++;
        step(1'b0, 1'b0, 4'h0);
        if (bus.frame_valid !== 1'b0 || frame !== 16'h1234) begin
            $display("FAIL basic_pulse_clear: got fv=%b frame=%h want 0 1234", bus.frame_valid, frame); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_gapped_frame;
        logic [3:0] words [4];
        words = '{4'h5, 4'hA, 4'h5, 4'hA};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, words[i]);
            if (i < 3) begin
                if (bus.frame_valid !== 1'b0 || frame !== 16'h1234) begin
                    $display("FAIL gap_word_%0d: got fv=%b frame=%h want 0 1234", i, bus.frame_valid, frame); n_fail++;
                end
                n_checks++;
                for (int g = 0; g < 2; g++) begin
                    step(1'b0, 1'b0, 4'hF);
                    if (bus.frame_valid !== 1'b0 || frame !== 16'h1234) begin
                        $display("FAIL gap_idle_%0d_%0d: got fv=%b frame=%h want 0 1234", i, g, bus.frame_valid, frame); n_fail++;
                    end
                    n_checks++;
                end
            end
        end
        if (bus.frame_valid !== 1'b1 || frame !== 16'h5A5A) begin
            $display("FAIL gap_commit: got fv=%b frame=%h want 1 5a5a", bus.frame_valid, frame); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_sync_mid_frame;
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h8);
        step(1'b1, 1'b1, 4'h9);
        if (bus.frame_abort !== 1'b1 || bus.frame_valid !== 1'b0) begin
            $display("FAIL sync_abort: got fa=%b fv=%b want 1 0", bus.frame_abort, bus.frame_valid); n_fail++;
        end
        n_checks++;
        step(1'b1, 1'b0, 4'h1);
        if (bus.frame_abort !== 1'b0) begin
            $display("FAIL sync_abort_clear: got fa=%b want 0", bus.frame_abort); n_fail++;
        end
        n_checks++;
        step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b0, 4'h3);
        if (bus.frame_valid !== 1'b1 || bus.frame_abort !== 1'b0 || frame !== 16'h9123) begin
            $display("FAIL sync_commit: got fv=%b fa=%b frame=%h want 1 0 9123", bus.frame_valid, bus.frame_abort, frame); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_sync_idle;
        step(1'b1, 1'b0, 4'h5);
        step(1'b0, 1'b1, 4'hE);
        if (bus.frame_abort !== 1'b1 || frame !== 16'h9123) begin
            $display("FAIL sync_idle_abort: got fa=%b frame=%h want 1 9123", bus.frame_abort, frame); n_fail++;
        end
        n_checks++;
        step(1'b0, 1'b1, 4'hE);
        if (bus.frame_abort !== 1'b0) begin
            $display("FAIL sync_idle_slot0: got fa=%b want 0", bus.frame_abort); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_frame;
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        #2;
        rst_n = 1'b0;
        #1;
        if (frame !== 16'h0000 || bus.frame_valid !== 1'b0 || bus.frame_abort !== 1'b0) begin
            $display("FAIL rst_async: got frame=%h fv=%b fa=%b want 0000 0 0", frame, bus.frame_valid, bus.frame_abort); n_fail++;
        end
        n_checks++;
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b0, 4'h0);
            if (bus.frame_valid !== 1'b0 || bus.frame_abort !== 1'b0) begin
                $display("FAIL rst_hold_%0d: got fv=%b fa=%b want 0 0", c, bus.frame_valid, bus.frame_abort); n_fail++;
            end
            n_checks++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h3);
        if (bus.frame_valid !== 1'b1 || frame !== 16'h3333) begin
            $display("FAIL rst_refill: got fv=%b frame=%h want 1 3333", bus.frame_valid, frame); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 4'(i));
            if (bus.frame_valid !== ((i % 4) == 3)) begin
                $display("FAIL b2b_fv_%0d: got %b want %b", i, bus.frame_valid, ((i % 4) == 3)); n_fail++;
            end
            n_checks++;
            if (i == 3 && frame !== 16'h0123) begin
                $display("FAIL b2b_frame0: got %h want 0123", frame); n_fail++;
            end
            if (i == 7 && frame !== 16'h4567) begin
                $display("FAIL b2b_frame1: got %h want 4567", frame); n_fail++;
            end
            if (i == 3 || i == 7) n_checks++;
        end
    endtask
`else
    task automatic ext_step(input logic [1:0] sel, input logic [3:0] d);
        bus.s = sel;
        step(1'b1, 1'b0, d);
    endtask

    task automatic test_ext_sel;
        ext_step(2'd2, 4'hC);
        if (bus.frame_valid !== 1'b0 || bus.frame_abort !== 1'b0) begin
            $display("FAIL ext_w2: got fv=%b fa=%b want 0 0", bus.frame_valid, bus.frame_abort); n_fail++;
        end
        n_checks++;
        ext_step(2'd0, 4'hD);
        if (bus.frame_valid !== 1'b0 || bus.frame_abort !== 1'b0) begin
            $display("FAIL ext_w0: got fv=%b fa=%b want 0 0", bus.frame_valid, bus.frame_abort); n_fail++;
        end
        n_checks++;
        ext_step(2'd3, 4'hE);
        if (bus.frame_valid !== 1'b1 || bus.frame_abort !== 1'b0 || frame !== 16'hD0CE) begin
            $display("FAIL ext_commit: got fv=%b fa=%b frame=%h want 1 0 d0ce", bus.frame_valid, bus.frame_abort, frame); n_fail++;
        end
        n_checks++;
        bus.s = 2'd3;
        step(1'b1, 1'b1, 4'h9);
        if (bus.frame_abort !== 1'b0 || bus.frame_valid !== 1'b0) begin
            $display("FAIL ext_sync: got fa=%b fv=%b want 0 0", bus.frame_abort, bus.frame_valid); n_fail++;
        end
        n_checks++;
        ext_step(2'd3, 4'h1);
        if (bus.frame_valid !== 1'b1 || frame !== 16'h0001) begin
            $display("FAIL ext_cleared: got fv=%b frame=%h want 1 0001", bus.frame_valid, frame); n_fail++;
        end
        n_checks++;
    endtask
`endif

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
`ifdef DEMUX_EXT_SEL_EN
        bus.s         = '0;
`endif
        rst_n         = 1'b0;
        #1;
        test_reset;
`ifndef DEMUX_EXT_SEL_EN
        test_basic_frame;
        test_gapped_frame;
        test_sync_mid_frame;
        test_sync_idle;
        test_reset_mid_frame;
        test_back_to_back;
`else
        test_ext_sel;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
